vram_snoop: RTL and testbench
=============================

// Module: vram_snoop
// PURPOSE
//  Shadow screen memory feeding the video controller. Snoops Z80 memory writes into RAM pages 5 and 7 and
//  mirrors them into a 32 KB dual-port BRAM: bank 0 holds page 5, bank 1 holds page 7.
//  Also accepts bulk writes from the snapshot/loader path.
//  Serves the video fetch port (vram_addr/vram_dout) with a fixed 1-clk_sys read latency.
//  The video side therefore never contends with the CPU for main SDRAM.
// PARAMETERS
//  FIFO_DEPTH  4   CPU write-queue entries; power of two, minimum 2.
//  ADDR_W      14  Byte address width inside one 16 KB bank.
// PORTS
//  clk_sys     in   1   System clock; all logic on its rising edge.
//  reset       in   1   Synchronous, active-high.
//  addr        in   16  Z80 address bus.
//  din         in   8   Z80 data out (write data).
//  nMREQ       in   1   Z80 memory request, active low.
//  nWR         in   1   Z80 write strobe, active low.
//  nRFSH       in   1   Z80 refresh, active low; a refresh cycle is never a write.
//  m128        in   1   128K paging active.
//  page_ram    in   3   RAM page mapped at 0xC000.
//  ld_valid    in   1   Loader write request.
//  ld_ready    out  1   Loader write accepted this clock when high together with ld_valid.
//  ld_bank     in   1   Loader target bank (0 = page 5, 1 = page 7).
//  ld_addr     in   14  Loader byte address.
//  ld_data     in   8   Loader byte.
//  vram_addr   in   15  Video fetch address {bank, offset}.
//  vram_dout   out  8   Video fetch data, registered.
//  ovf         out  1   Sticky write-queue overflow flag.
// BEHAVIOUR
//  - Write detect: wr = ~nMREQ & ~nWR & nRFSH.
//    Capture on the rising edge of wr (previous-clock register old_wr), i.e. exactly one push per Z80 write cycle.
//  - Bank decode: addr[15:14]==01 gives bank 0.
//    m128 & addr[15:14]==11 & page_ram==5 gives bank 0; page_ram==7 gives bank 1.
//    Any other address is ignored (no push).
//  - Push {bank, addr[13:0], din} into the write queue in the same clock as the detected edge.
//  - Queue full at push: the entry is dropped, ovf sets to 1 and holds until reset. Queue contents are unchanged.
//  - Port A arbitration, once per clock:
//    - Queue non-empty: pop one entry and write it to BRAM; ld_ready=0.
//    - Queue empty: ld_ready=1; if ld_valid, write the loader byte.
//    - The CPU queue always has priority; the loader stalls until the queue is empty.
//  - Simultaneous push and pop on a non-empty queue: both occur, occupancy unchanged.
//    Push into an empty queue: the entry is written to BRAM on the next clock (write latency 1-2 clk_sys).
//  - ld_ready is combinational from queue-empty and is forced 0 while reset is high.
//  - Port B: vram_dout <= mem[vram_addr] every clock, latency 1.
//    Read-first: a same-clock port-A write to the same address returns the old byte; the new byte appears on the next read.
//  - Reset values:
//    - Queue pointers and count 0.
//    - ovf=0, old_wr=0, vram_dout=8'h00.
//    - BRAM contents are NOT cleared.
//  - Reset mid-operation: queued entries are discarded; a loader beat presented during reset is not accepted.
//  - Pointer wrap: pointers are log2(FIFO_DEPTH)+1 bits.
//    Full when the MSBs differ and the low bits are equal; empty when the pointers are equal.
// STRUCTURE
//  - Package zx_vram_pkg:
//    - typedef vram_wr_t {logic bank; logic [13:0] a; logic [7:0] d;}.
//    - Constants PAGE_SCR0=3'd5 and PAGE_SCR1=3'd7.
//  - Sub-module vram_wq: synchronous FIFO of vram_wr_t with push/pop/full/empty.
//  - The top level holds edge detect, decode, arbitration and the inferred dual-port BRAM (reg [7:0] mem[32768]).
// TESTING
//  1. Write 0x4000<=0xA5 (one Z80 write cycle), then read vram_addr=0x0000 -> 0xA5 one clock later; queue count returns to 0.
//  2. m128=1, page_ram=7: write 0xC123<=0x3C -> vram_addr=0x4123 reads 0x3C.
//     page_ram=3: same write -> no push, memory unchanged.
//  3. Refresh cycle (nRFSH=0, nMREQ=0) with nWR=0 and address 0x5000 -> no push.
//     A write held low for 6 clocks -> exactly one push.
//  4. ld_valid held with 3 queued CPU writes -> ld_ready=0 for 3 clocks, then 1.
//     Loader byte 0x77 to bank 1, offset 0x0010 -> read 0x4010 gives 0x77.
//  5. 5 pushes with pops blocked (back-to-back edges on a forced-stall bench) -> 4 entries kept, ovf=1 sticky.
//     reset -> ovf=0, vram_dout=0, queue empty.
//  6. Port-A write 0x11 and port-B read of the same address in the same clock -> old byte returned; the next clock returns 0x11.

Source files
------------

// File: rtl/zx_vram_pkg.sv
// -----------------------------------------------------------------------------
// zx_vram_pkg
// Shared types and constants for the shadow screen memory (vram_snoop).
//   vram_wr_t  : one queued write {bank, 14-bit byte offset, data byte}
//   PAGE_SCR0  : 128K RAM page mirrored into bank 0
//   PAGE_SCR1  : 128K RAM page mirrored into bank 1
//   bram_index : flattens a queued write into the 15-bit BRAM address
// -----------------------------------------------------------------------------
package zx_vram_pkg;

  localparam logic [2:0] PAGE_SCR0 = 3'd5;
  localparam logic [2:0] PAGE_SCR1 = 3'd7;

  typedef struct packed {
    logic        bank;
    logic [13:0] a;
    logic [7:0]  d;
  } vram_wr_t;

  function automatic logic [14:0] bram_index(input vram_wr_t w);
    return {w.bank, w.a};
  endfunction

endpackage

// File: rtl/vram_wq.sv
// -----------------------------------------------------------------------------
// vram_wq
// Synchronous FIFO of vram_wr_t entries buffering snooped CPU writes until the
// BRAM write port is free. Pointers carry one extra wrap bit so full and empty
// are told apart without a separate counter.
// Ports:
//   clk_sys  in   system clock, rising edge
//   reset    in   synchronous active-high; empties the queue, clears o_ovf
//   i_push   in   enqueue i_wdata (dropped when full)
//   i_wdata  in   entry to enqueue
//   i_pop    in   dequeue head entry (ignored when empty)
//   o_rdata  out  head entry (valid while o_empty is low)
//   o_full   out  queue holds DEPTH entries
//   o_empty  out  queue holds no entries
//   o_ovf    out  sticky: a push was attempted while full
// -----------------------------------------------------------------------------
module vram_wq
  import zx_vram_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic     clk_sys,
  input  logic     reset,
  input  logic     i_push,
  input  vram_wr_t i_wdata,
  input  logic     i_pop,
  output vram_wr_t o_rdata,
  output logic     o_full,
  output logic     o_empty,
  output logic     o_ovf
);

  localparam int PW = $clog2(DEPTH);

  vram_wr_t        r_mem [DEPTH];
  logic [PW:0]     r_wptr;
  logic [PW:0]     r_rptr;
  logic            r_ovf;
  logic            w_do_push;
  logic            w_do_pop;

  assign o_empty   = (r_wptr == r_rptr);
  assign o_full    = (r_wptr[PW] != r_rptr[PW]) &&
                     (r_wptr[PW-1:0] == r_rptr[PW-1:0]);
  assign w_do_push = i_push & ~o_full;
  assign w_do_pop  = i_pop & ~o_empty;
  assign o_rdata   = r_mem[r_rptr[PW-1:0]];
  assign o_ovf     = r_ovf;

  // NOTE: state registers use non-blocking assignment so every flop samples
  // the pre-edge value of every other flop, independent of statement order.
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      r_wptr <= '0;
      r_rptr <= '0;
      r_ovf  <= 1'b0;
    end else begin
      if (w_do_push) r_wptr <= r_wptr + 1'b1;
      if (w_do_pop)  r_rptr <= r_rptr + 1'b1;
      if (i_push && o_full) r_ovf <= 1'b1;
    end
  end

  // NOTE: storage is deliberately not reset; the pointers alone define which
  // entries are live, and leaving the array reset-free lets it map to RAM.
  always_ff @(posedge clk_sys) begin
    if (w_do_push) r_mem[r_wptr[PW-1:0]] <= i_wdata;
  end

endmodule

// File: rtl/vram_snoop.sv
// -----------------------------------------------------------------------------
// vram_snoop
// Shadow screen memory for the video controller. Snoops Z80 writes into RAM
// pages 5 and 7, queues them, and mirrors them into a 32 KB dual-port BRAM
// (bank 0 = page 5, bank 1 = page 7). The loader path writes the same BRAM
// whenever the CPU queue is empty. Port B serves video fetches with a fixed
// one-clock latency, read-first.
// Ports:
//   clk_sys    in   system clock
//   reset      in   synchronous active-high
//   addr/din   in   Z80 address and write data
//   nMREQ/nWR  in   Z80 memory request / write strobe (active low)
//   nRFSH      in   Z80 refresh (active low); refresh never counts as a write
//   m128       in   128K paging enabled
//   page_ram   in   RAM page mapped at 0xC000
//   ld_valid   in   loader beat present
//   ld_ready   out  loader beat accepted when high with ld_valid
//   ld_bank/ld_addr/ld_data  in  loader target and byte
//   vram_addr  in   video fetch address {bank, offset}
//   vram_dout  out  video fetch data, registered
//   ovf        out  sticky write-queue overflow
// -----------------------------------------------------------------------------
module vram_snoop
  import zx_vram_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int ADDR_W     = 14
) (
  input  logic              clk_sys,
  input  logic              reset,
  input  logic [15:0]       addr,
  input  logic [7:0]        din,
  input  logic              nMREQ,
  input  logic              nWR,
  input  logic              nRFSH,
  input  logic              m128,
  input  logic [2:0]        page_ram,
  input  logic              ld_valid,
  output logic              ld_ready,
  input  logic              ld_bank,
  input  logic [ADDR_W-1:0] ld_addr,
  input  logic [7:0]        ld_data,
  input  logic [ADDR_W:0]   vram_addr,
  output logic [7:0]        vram_dout,
  output logic              ovf
);

  localparam int MEM_WORDS = 2 ** (ADDR_W + 1);

  logic            r_old_wr;
  logic            w_wr;
  logic            w_wr_edge;
  logic            w_hit;
  logic            w_bank;
  logic            w_push;
  logic            w_pop;
  logic            w_empty;
  logic            w_full;
  logic            w_ld_acc;
  vram_wr_t        w_push_data;
  vram_wr_t        w_head;
  logic            w_we;
  logic [ADDR_W:0] w_wa;
  logic [7:0]      w_wd;
  logic [7:0]      r_mem [MEM_WORDS];
  logic [7:0]      r_vram_dout;

  // A Z80 write cycle holds the strobe for several clocks; only its first
  // clock pushes, so the queue sees exactly one entry per bus cycle.
  assign w_wr      = ~nMREQ & ~nWR & nRFSH;
  assign w_wr_edge = w_wr & ~r_old_wr;

  always_ff @(posedge clk_sys) begin
    if (reset) r_old_wr <= 1'b0;
    else       r_old_wr <= w_wr;
  end

  // NOTE: every output of a combinational block gets a default first, so no
  // path through the if/else leaves a signal unassigned (no latch).
  always_comb begin
    w_hit  = 1'b0;
    w_bank = 1'b0;
    if (addr[15:14] == 2'b01) begin
      w_hit = 1'b1;
    end else if (m128 && addr[15:14] == 2'b11) begin
      if (page_ram == PAGE_SCR0) begin
        w_hit = 1'b1;
      end else if (page_ram == PAGE_SCR1) begin
        w_hit  = 1'b1;
        w_bank = 1'b1;
      end
    end
  end

  assign w_push      = w_wr_edge & w_hit & ~reset;
  assign w_push_data = '{bank: w_bank, a: addr[13:0], d: din};

  vram_wq #(.DEPTH(FIFO_DEPTH)) u_wq (
    .clk_sys (clk_sys),
    .reset   (reset),
    .i_push  (w_push),
    .i_wdata (w_push_data),
    .i_pop   (w_pop),
    .o_rdata (w_head),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_ovf   (ovf)
  );

  // Port A: the CPU queue always wins; the loader only gets the port on a
  // clock where the queue is empty. Nothing is written while in reset.
  assign w_pop    = ~w_empty & ~reset;
  assign ld_ready = w_empty & ~reset;
  assign w_ld_acc = ld_valid & ld_ready;
  assign w_we     = w_pop | w_ld_acc;
  assign w_wa     = w_pop ? bram_index(w_head) : {ld_bank, ld_addr};
  assign w_wd     = w_pop ? w_head.d : ld_data;

  always_ff @(posedge clk_sys) begin
    if (w_we) r_mem[w_wa] <= w_wd;
  end

  // Port B: read-first falls out of sampling the array before the port-A
  // update of the same edge lands.
  always_ff @(posedge clk_sys) begin
    if (reset) r_vram_dout <= 8'h00;
    else       r_vram_dout <= r_mem[vram_addr];
  end

  assign vram_dout = r_vram_dout;

endmodule

// File: tb/tb_vram_snoop.sv
module tb_vram_snoop;
  import zx_vram_pkg::*;

  logic        clk_sys = 1'b0;
  logic        reset;
  logic [15:0] addr;
  logic [7:0]  din;
  logic        nMREQ, nWR, nRFSH, m128;
  logic [2:0]  page_ram;
  logic        ld_valid, ld_ready, ld_bank;
  logic [13:0] ld_addr;
  logic [7:0]  ld_data;
  logic [14:0] vram_addr;
  logic [7:0]  vram_dout;
  logic        ovf;

  // Standalone queue instance: the top can never fill its own queue because
  // the Z80 produces at most one push every two clocks against a pop per clock.
  logic     q_reset, q_push, q_pop, q_full, q_empty, q_ovf;
  vram_wr_t q_wdata, q_rdata;

  int checks = 0;
  int failures = 0;

  logic [7:0] model_mem [32768];
  bit         model_known [32768];
  int         written [$];

  always #5 clk_sys = ~clk_sys;

  vram_snoop #(.FIFO_DEPTH(4), .ADDR_W(14)) dut (
    .clk_sys(clk_sys), .reset(reset), .addr(addr), .din(din),
    .nMREQ(nMREQ), .nWR(nWR), .nRFSH(nRFSH), .m128(m128), .page_ram(page_ram),
    .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_bank(ld_bank),
    .ld_addr(ld_addr), .ld_data(ld_data), .vram_addr(vram_addr),
    .vram_dout(vram_dout), .ovf(ovf)
  );

  vram_wq #(.DEPTH(4)) u_wq (
    .clk_sys(clk_sys), .reset(q_reset), .i_push(q_push), .i_wdata(q_wdata),
    .i_pop(q_pop), .o_rdata(q_rdata), .o_full(q_full), .o_empty(q_empty),
    .o_ovf(q_ovf)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_sys);
    #1;
  endtask

  // Reference decode from the address map: returns BRAM index or -1.
  function automatic int model_target(input logic [15:0] a, input bit m, input logic [2:0] pg);
    int ai;
    ai = int'(a);
    if (ai >= 'h4000 && ai < 'h8000) return ai - 'h4000;
    if (m && ai >= 'hC000 && pg == 3'd5) return ai - 'hC000;
    if (m && ai >= 'hC000 && pg == 3'd7) return 16384 + ai - 'hC000;
    return -1;
  endfunction

  function automatic void model_write(input int idx, input logic [7:0] d);
    if (!model_known[idx]) written.push_back(idx);
    model_known[idx] = 1'b1;
    model_mem[idx] = d;
  endfunction

  // One Z80 write cycle with the strobe held for 'hold' clocks; counts clocks
  // on which the loader was locked out.
  task automatic z80_write(input logic [15:0] a, input logic [7:0] d, input int hold,
                           output int low_cycles);
    int t;
    t = model_target(a, m128, page_ram);
    addr = a; din = d; nMREQ = 1'b0; nWR = 1'b0;
    low_cycles = 0;
    for (int i = 0; i < hold; i++) begin
      tick();
      if (!ld_ready) low_cycles++;
    end
    nMREQ = 1'b1; nWR = 1'b1;
    tick();
    if (!ld_ready) low_cycles++;
    tick();
    if (t >= 0) model_write(t, d);
  endtask

  task automatic ld_write(input logic b, input logic [13:0] a, input logic [7:0] d);
    ld_valid = 1'b1; ld_bank = b; ld_addr = a; ld_data = d;
    for (int n = 0; n < 50 && !ld_ready; n++) tick();
    check("ld_wait", ld_ready, 1'b1);
    tick();
    ld_valid = 1'b0;
    model_write(int'({b, a}), d);
  endtask

  task automatic read_chk(input string name, input logic [14:0] idx, input logic [7:0] exp);
    vram_addr = idx;
    tick();
    check(name, vram_dout, exp);
  endtask

  typedef struct {
    logic [15:0] a;
    logic [7:0]  d;
    bit          m;
    logic [2:0]  pg;
    logic [14:0] rd;
    logic [7:0]  exp;
    int          exp_low;
  } vec_t;

  vec_t vecs [9];

  initial begin
    int low, t, idx;
    logic [15:0] ra;

    vecs[0] = '{16'h4000, 8'hA5, 1'b0, 3'd0, 15'h0000, 8'hA5, 1};
    vecs[1] = '{16'hC123, 8'h3C, 1'b1, 3'd7, 15'h4123, 8'h3C, 1};
    vecs[2] = '{16'hC123, 8'h99, 1'b1, 3'd3, 15'h4123, 8'h3C, 0};
    vecs[3] = '{16'hC200, 8'h5A, 1'b1, 3'd5, 15'h0200, 8'h5A, 1};
    vecs[4] = '{16'hC200, 8'h66, 1'b0, 3'd5, 15'h0200, 8'h5A, 0};
    vecs[5] = '{16'h8000, 8'h11, 1'b1, 3'd7, 15'h0000, 8'hA5, 0};
    vecs[6] = '{16'h7FFF, 8'hE7, 1'b0, 3'd0, 15'h3FFF, 8'hE7, 1};
    vecs[7] = '{16'h0000, 8'h22, 1'b1, 3'd7, 15'h0000, 8'hA5, 0};
    vecs[8] = '{16'hFFFF, 8'hC3, 1'b1, 3'd7, 15'h7FFF, 8'hC3, 1};

    reset = 1'b1; addr = 16'h0; din = 8'h0; nMREQ = 1'b1; nWR = 1'b1; nRFSH = 1'b1;
    m128 = 1'b0; page_ram = 3'd0; ld_valid = 1'b0; ld_bank = 1'b0; ld_addr = '0;
    ld_data = 8'h0; vram_addr = '0;
    q_reset = 1'b1; q_push = 1'b0; q_pop = 1'b0; q_wdata = '0;
    for (int i = 0; i < 32768; i++) model_known[i] = 1'b0;

    tick(); tick();
    check("rst_ld_ready", ld_ready, 1'b0);
    check("rst_ovf", ovf, 1'b0);
    check("rst_dout", vram_dout, 8'h00);
    reset = 1'b0; q_reset = 1'b0;
    tick();
    check("post_rst_ready", ld_ready, 1'b1);

    // Table of single Z80 write cycles: loader lockout and resulting memory.
    foreach (vecs[i]) begin
      m128 = vecs[i].m; page_ram = vecs[i].pg;
      z80_write(vecs[i].a, vecs[i].d, 1, low);
      check($sformatf("vec%0d_low", i), low, vecs[i].exp_low);
      read_chk($sformatf("vec%0d_rd", i), vecs[i].rd, vecs[i].exp);
    end

    // Long strobe: one push only.
    m128 = 1'b0;
    z80_write(16'h4100, 8'h81, 6, low);
    check("hold6_low", low, 1);
    read_chk("hold6_rd", 15'h0100, 8'h81);

    // Refresh cycle with nWR low never writes.
    ld_write(1'b0, 14'h1000, 8'h44);
    addr = 16'h5000; din = 8'hEE; nMREQ = 1'b0; nWR = 1'b0; nRFSH = 1'b0;
    low = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (!ld_ready) low++;
    end
    nMREQ = 1'b1; nWR = 1'b1; nRFSH = 1'b1;
    tick(); tick();
    check("rfsh_low", low, 0);
    read_chk("rfsh_rd", 15'h1000, 8'h44);

    // CPU priority over a waiting loader beat.
    m128 = 1'b1; page_ram = 3'd7;
    addr = 16'hC011; din = 8'h55; nMREQ = 1'b0; nWR = 1'b0;
    tick();
    check("prio_busy", ld_ready, 1'b0);
    ld_valid = 1'b1; ld_bank = 1'b1; ld_addr = 14'h0010; ld_data = 8'h77;
    nMREQ = 1'b1; nWR = 1'b1;
    tick();
    check("prio_free", ld_ready, 1'b1);
    tick();
    ld_valid = 1'b0;
    tick();
    model_write(16384 + 'h11, 8'h55);
    model_write(16384 + 'h10, 8'h77);
    read_chk("prio_ld_rd", 15'h4010, 8'h77);
    read_chk("prio_cpu_rd", 15'h4011, 8'h55);

    // Read-first on a same-clock write.
    ld_write(1'b1, 14'h0200, 8'h22);
    vram_addr = 15'h4200;
    ld_valid = 1'b1; ld_bank = 1'b1; ld_addr = 14'h0200; ld_data = 8'h11;
    tick();
    ld_valid = 1'b0;
    check("rf_old", vram_dout, 8'h22);
    tick();
    check("rf_new", vram_dout, 8'h11);
    model_write(16384 + 'h200, 8'h11);

    // Reset mid-operation discards the queued entry and the loader beat.
    ld_write(1'b0, 14'h0300, 8'h33);
    ld_write(1'b0, 14'h0301, 8'h34);
    m128 = 1'b0;
    addr = 16'h4300; din = 8'hDD; nMREQ = 1'b0; nWR = 1'b0;
    tick();
    reset = 1'b1; nMREQ = 1'b1; nWR = 1'b1;
    ld_valid = 1'b1; ld_bank = 1'b0; ld_addr = 14'h0301; ld_data = 8'hBB;
    check("midrst_ready", ld_ready, 1'b0);
    tick();
    check("midrst_dout", vram_dout, 8'h00);
    check("midrst_ovf", ovf, 1'b0);
    tick();
    reset = 1'b0; ld_valid = 1'b0;
    tick();
    read_chk("midrst_q", 15'h0300, 8'h33);
    read_chk("midrst_ld", 15'h0301, 8'h34);

    // Randomized traffic against the address-map model.
    for (int it = 0; it < 250; it++) begin
      case ($urandom_range(0, 2))
        0: begin
          ra = {2'($urandom_range(0, 3)), 8'h00, 6'($urandom_range(0, 63))};
          m128 = 1'($urandom);
          page_ram = 3'($urandom);
          t = model_target(ra, m128, page_ram);
          z80_write(ra, 8'($urandom), $urandom_range(1, 3), low);
          check("rnd_low", low, (t >= 0) ? 1 : 0);
        end
        1: ld_write(1'($urandom), 14'($urandom_range(0, 63)), 8'($urandom));
        default: begin
          if (written.size() > 0) begin
            idx = written[$urandom_range(0, written.size() - 1)];
            read_chk("rnd_rd", 15'(idx), model_mem[idx]);
          end
        end
      endcase
    end
    check("top_ovf", ovf, 1'b0);

    // Queue: overflow drops the fifth entry and the flag sticks.
    for (int k = 0; k < 5; k++) begin
      q_push = 1'b1;
      q_wdata = '{bank: 1'b0, a: 14'(k), d: 8'(8'h10 + k)};
      tick();
      if (k == 3) begin
        check("q_full", q_full, 1'b1);
        check("q_ovf_pre", q_ovf, 1'b0);
      end
    end
    q_push = 1'b0;
    check("q_ovf", q_ovf, 1'b1);
    for (int k = 0; k < 4; k++) begin
      check($sformatf("q_data%0d", k), q_rdata.d, 8'(8'h10 + k));
      q_pop = 1'b1;
      tick();
      q_pop = 1'b0;
    end
    check("q_empty", q_empty, 1'b1);
    check("q_ovf_sticky", q_ovf, 1'b1);

    // Queue: simultaneous push and pop keeps occupancy.
    q_push = 1'b1; q_wdata = '{bank: 1'b1, a: 14'h1, d: 8'hA1}; tick();
    q_wdata = '{bank: 1'b1, a: 14'h2, d: 8'hB2}; tick();
    q_pop = 1'b1; q_wdata = '{bank: 1'b1, a: 14'h3, d: 8'hC3}; tick();
    q_push = 1'b0; q_pop = 1'b0;
    low = 0;
    for (int n = 0; n < 8 && !q_empty; n++) begin
      check($sformatf("q_sp%0d", low), q_rdata.d, (low == 0) ? 8'hB2 : 8'hC3);
      low++;
      q_pop = 1'b1;
      tick();
      q_pop = 1'b0;
    end
    check("q_sp_count", low, 2);

    q_reset = 1'b1;
    tick();
    q_reset = 1'b0;
    check("q_rst_ovf", q_ovf, 1'b0);
    check("q_rst_empty", q_empty, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
